// File: rtl/bus_intc_pkg.sv
// Shared constants for the bus interrupt controller: register offsets,
// FSM state encoding and the width of the source ID field.
package bus_intc_pkg;

    localparam int ID_W = 3;

    localparam logic [7:0] OFF_MASK    = 8'd0;
    localparam logic [7:0] OFF_PENDING = 8'd1;
    localparam logic [7:0] OFF_ACTIVE  = 8'd2;
    localparam logic [7:0] OFF_CTRL    = 8'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RAISE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

endpackage

// File: rtl/intc_priority_picker.sv
// Combinational winner select: fixed mode takes the lowest set index,
// round-robin searches upward from rr_ptr+1 and wraps at NUM_SRC-1.
module intc_priority_picker
    import bus_intc_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    input  logic               fixed_prio,
    output logic               win_vld,
    output logic [ID_W-1:0]    win_id
);

    int                 idx;
    logic [NUM_SRC-1:0] req_sh;

    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        idx     = 0;
        req_sh  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (fixed_prio) begin
                idx = k;
            end else begin
                idx = int'(rr_ptr) + 1 + k;
                if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            end
            req_sh = req >> idx;
            if (!win_vld && req_sh[0]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/bus_interrupt_controller.sv
// Latches peripheral interrupt edges, arbitrates them onto one CPU line and
// routes the CPU acknowledge back; registers live on an 8-bit tristate bus.
module bus_interrupt_controller
    import bus_intc_pkg::*;
#(
    parameter int         NUM_SRC   = 4,
    parameter logic [7:0] BaseAddr  = 8'hB0,
    parameter int         AddrWidth = 2
) (
    input  logic               CLK,
    input  logic               RESET,
    inout  wire  [7:0]         BUS_DATA,
    input  logic [7:0]         BUS_ADDR,
    input  logic               BUS_WE,
    input  logic [NUM_SRC-1:0] SRC_INTERRUPT_RAISE,
    output logic [NUM_SRC-1:0] SRC_INTERRUPT_ACK,
    output logic               CPU_INTERRUPT_RAISE,
    input  logic               CPU_INTERRUPT_ACK,
    output logic [ID_W-1:0]    CPU_INTERRUPT_ID
);

    localparam logic [8:0]         WIN_SIZE = 9'(2 ** AddrWidth);
    localparam logic [NUM_SRC-1:0] ONE      = NUM_SRC'(1);

    logic [NUM_SRC-1:0] src_q, src_d, src_prev_q, src_prev_d;
    logic [NUM_SRC-1:0] pending_q, pending_d, mask_q, mask_d;
    logic [NUM_SRC-1:0] src_ack_q, src_ack_d;
    logic               prio_q, prio_d;
    logic [1:0]         state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d, rr_q, rr_d;
    logic               rd_vld_q, rd_vld_d;
    logic [7:0]         rd_dat_q, rd_dat_d;

    logic [7:0]         offset;
    logic               hit, wr, ack_fire, pick_vld;
    logic [NUM_SRC-1:0] bus_low, act_oh, clr;
    logic [ID_W-1:0]    pick_id;

    assign offset   = BUS_ADDR - BaseAddr;
    assign hit      = (BUS_ADDR >= BaseAddr) && ({1'b0, offset} < WIN_SIZE);
    assign wr       = hit && BUS_WE;
    assign bus_low  = NUM_SRC'(BUS_DATA);
    assign act_oh   = ONE << id_q;
    assign ack_fire = (state_q == ST_RAISE) && CPU_INTERRUPT_ACK;

    intc_priority_picker #(.NUM_SRC(NUM_SRC)) u_picker (
        .req        (pending_q & mask_q),
        .rr_ptr     (rr_q),
        .fixed_prio (prio_q),
        .win_vld    (pick_vld),
        .win_id     (pick_id)
    );

    always_comb begin
        src_d      = SRC_INTERRUPT_RAISE;
        src_prev_d = src_q;
        // A fresh edge in the same cycle as a clear keeps the bit pending.
        clr        = ((wr && offset == OFF_PENDING) ? bus_low : '0) |
                     (ack_fire ? act_oh : '0);
        pending_d  = (pending_q & ~clr) | (src_q & ~src_prev_q);
        mask_d     = (wr && offset == OFF_MASK) ? bus_low : mask_q;
        prio_d     = (wr && offset == OFF_CTRL) ? BUS_DATA[0] : prio_q;

        state_d    = state_q;
        id_d       = id_q;
        rr_d       = rr_q;
        src_ack_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    id_d    = pick_id;
                    state_d = ST_RAISE;
                end
            end
            ST_RAISE: begin
                if (ack_fire) begin
                    src_ack_d = act_oh;
                    rr_d      = id_q;
                    state_d   = ST_GAP;
                end else if ((pending_d & act_oh) == '0) begin
                    // Software withdrew the request: drop it without a source ack.
                    state_d = ST_GAP;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rd_vld_d = hit && !BUS_WE;
        rd_dat_d = rd_dat_q;
        if (rd_vld_d) begin
            case (offset)
                OFF_MASK:    rd_dat_d = 8'(mask_q);
                OFF_PENDING: rd_dat_d = 8'(pending_q);
                OFF_ACTIVE:  rd_dat_d = {state_q == ST_RAISE, 4'b0000, id_q};
                OFF_CTRL:    rd_dat_d = {7'b0000000, prio_q};
                default:     rd_dat_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            src_q      <= '0;
            src_prev_q <= '0;
            pending_q  <= '0;
            mask_q     <= '1;
            prio_q     <= 1'b0;
            state_q    <= ST_IDLE;
            id_q       <= '0;
            rr_q       <= ID_W'(NUM_SRC - 1);
            src_ack_q  <= '0;
            rd_vld_q   <= 1'b0;
            rd_dat_q   <= 8'h00;
        end else begin
            src_q      <= src_d;
            src_prev_q <= src_prev_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            prio_q     <= prio_d;
            state_q    <= state_d;
            id_q       <= id_d;
            rr_q       <= rr_d;
            src_ack_q  <= src_ack_d;
            rd_vld_q   <= rd_vld_d;
            rd_dat_q   <= rd_dat_d;
        end
    end

    assign SRC_INTERRUPT_ACK   = src_ack_q;
    assign CPU_INTERRUPT_RAISE = (state_q == ST_RAISE);
    assign CPU_INTERRUPT_ID    = id_q;
    assign BUS_DATA            = rd_vld_q ? rd_dat_q : 8'hzz;

endmodule
